math_result_serializer: RTL and testbench
=========================================

# math_result_serializer

Downstream consumer of the `math_expression` datapath. Captures every one-cycle `valid` tick carrying a signed quotient `q` and remainder bit `rmd` into a small FIFO. Emits each captured result as a byte frame on an 8-bit valid/ready stream, for a UART/host link. The producer has no backpressure, so the block absorbs bursts and records any result it drops.

## Interface
- `W`, default 16: width of the signed quotient; must be ≥ 2.
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  one-cycle result tick from the upstream datapath.
- `in_q`  in  W  signed quotient; sampled when `in_valid`=1.
- `in_rmd`  in  1  remainder bit; sampled when `in_valid`=1.
- `out_data`  out  8  current frame byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts the byte this cycle.
- `overflow`  out  1  sticky: at least one result was dropped since reset.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy (registered).
- `busy`  out  1  FIFO non-empty or a frame is in progress.

## Operation
- NQ = ceil(W/8). Each frame is NQ+1 bytes.
- Frame layout:
  - NQ bytes of `q`, sign-extended to 8·NQ bits, least-significant byte first.
  - Then one status byte: bit0 = rmd, bit1 = sign of q, bit2 = drop flag, bits7:3 = 0.
- Drop flag: set when at least one result was dropped after the previous frame's status byte was accepted. It is cleared when this status byte is accepted.
- Capture: when `in_valid`=1 and registered `count` < DEPTH, write {q, rmd} and increment `count`.
- Drop: when `in_valid`=1 and `count` == DEPTH, discard the result, set `overflow` and the pending drop flag.
- Full test uses the registered `count` from before any same-cycle pop. A write during a pop cycle while full is therefore dropped.
- Serializer FSM, two states:
  - IDLE: `out_valid`=0. If FIFO non-empty, pop the head into the shift register, set byte index 0, go to SEND.
  - SEND: `out_valid`=1 and `out_data` = byte[index].
    - On `out_ready`, advance the index.
    - On acceptance of the last byte: if the FIFO is non-empty, pop the next entry and stay in SEND with index 0 (no bubble). Otherwise go to IDLE.
- Simultaneous push and pop: `count` is unchanged. The written entry is stored and the popped entry is removed correctly.
- Pointers wrap modulo DEPTH.
- Reset values: `out_valid`=0, `out_data`=0, `overflow`=0, `count`=0, `busy`=0, drop flag=0, FSM=IDLE, pointers=0.
- Reset mid-frame or with entries queued discards everything. No partial frame resumes after reset.

## Timing
- Latency: `in_valid` at edge E writes the FIFO at E. The pop happens at E+1, so `out_valid` and the first byte appear after E+1, i.e. two cycles.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0. `out_valid` never deasserts mid-frame.
- Sustained rate: one byte per cycle with `out_ready`=1. One result takes NQ+1 cycles. Upstream ticks arriving faster than that fill the FIFO.
- `count` and `overflow` are registered and update at the edge after the event.

## Structure
- Shared package `math_pkg` holds:
  - the FSM state typedef (IDLE, SEND);
  - the status-byte bit-position constants (RMD_BIT=0, SIGN_BIT=1, DROP_BIT=2);
  - a function computing NQ from W.
- Sub-module `result_fifo`: parameterised W+1 wide, DEPTH deep, synchronous; push/pop/full/empty/count.
- The serializer FSM and drop-flag logic live in the top module.

## Test plan
Scenarios use W=16, DEPTH=4.
- Single result: q=-3, rmd=1, `out_ready`=1 → bytes 0xFD, 0xFF, 0x03. First byte appears 2 cycles after `in_valid`. `busy` returns to 0.
- Backpressure: q=0x1234, rmd=0. Hold `out_ready`=0 for 5 cycles, then 1 → 0x34 held stable for the stall, then 0x34, 0x12, 0x00.
- Burst overflow: 6 consecutive `in_valid` ticks (q=1..6) with `out_ready`=0 → q=1 is in flight, FIFO holds 2–5, q=6 is dropped, `overflow`=1. The status byte of the q=2 frame has bit2=1 and later frames have bit2=0.
- Back-to-back frames: two results queued, `out_ready`=1 → 6 consecutive valid bytes with no idle cycle between frames.
- Push+pop when full: `count`=4 and `in_valid` coincides with a pop → new result dropped, `overflow`=1, `count`=3 after the edge.
- Reset mid-frame after byte 0 is accepted → the next cycle shows `out_valid`=0, `count`=0, `overflow`=0. A new result then produces a complete, correct frame.

Source files
------------

// File: rtl/math_pkg.sv
// -----------------------------------------------------------------------------
// math_pkg
// Shared definitions for the math_expression result path:
//   - serializer FSM state type
//   - bit positions inside the frame status byte
//   - calc_nq(): number of bytes needed to carry a W-bit quotient
// -----------------------------------------------------------------------------
package math_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    localparam int RMD_BIT  = 0;
    localparam int SIGN_BIT = 1;
    localparam int DROP_BIT = 2;

    function automatic int calc_nq(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Synchronous FIFO holding captured {q, rmd} results.
// Ports:
//   clk, reset         clock, synchronous active-high reset (pointers/count)
//   push_i, wr_data_i  write request and data; ignored while full
//   pop_i              read request; ignored while empty
//   rd_data_o          head entry (combinational read of the head slot)
//   full_o, empty_o    status derived from the registered count
//   count_o            registered occupancy
// -----------------------------------------------------------------------------
module result_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count, so a push in a pop cycle
    // while full is still refused.
    assign full_o    = (count_q == (AW + 1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/math_result_serializer.sv
// -----------------------------------------------------------------------------
// math_result_serializer
// Buffers one-cycle {q, rmd} result ticks in a FIFO and sends each one as a
// frame of NQ sign-extended quotient bytes (LSB first) plus a status byte
// {5'b0, drop, sign, rmd} on an 8-bit valid/ready stream.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid, in_q, in_rmd  result tick from the datapath (no backpressure)
//   out_data, out_valid, out_ready  byte stream towards the host link
//   overflow              sticky: a result was dropped since reset
//   count                 registered FIFO occupancy
//   busy                  FIFO non-empty or a frame in progress
// -----------------------------------------------------------------------------
module math_result_serializer
    import math_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_q,
    input  logic                   in_rmd,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);

    localparam int NQ    = calc_nq(W);
    localparam int QW    = 8 * NQ;
    localparam int FW    = 8 * (NQ + 1);
    localparam int IDX_W = $clog2(NQ + 1);

    logic [W:0]       fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    ser_state_e       state_q, state_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             drop_pend_q, drop_pend_d;
    logic             overflow_q;

    logic [W-1:0]     q_raw;
    logic [QW-1:0]    q_ext;
    logic [7:0]       status_b;

    result_fifo #(
        .WIDTH (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (in_valid),
        .wr_data_i ({in_q, in_rmd}),
        .pop_i     (pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (count)
    );

    assign drop = in_valid && fifo_full;

    // Frame image of the FIFO head; the status byte sits in the top byte so
    // that shifting right by 8 walks the frame in transmit order.
    always_comb begin
        q_raw    = fifo_rd[W:1];
        q_ext    = QW'($signed(q_raw));
        status_b = '0;
        status_b[RMD_BIT]  = fifo_rd[0];
        status_b[SIGN_BIT] = q_raw[W-1];
        status_b[DROP_BIT] = drop_pend_q;
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) pop = 1'b1;
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == IDX_W'(NQ)) begin
                        // Last byte taken: chain straight into the next frame.
                        if (!fifo_empty) pop = 1'b1;
                        else             state_d = IDLE;
                    end else begin
                        frame_d = frame_q >> 8;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            frame_d = {status_b, q_ext};
            idx_d   = '0;
            state_d = SEND;
        end
        // Pending drops are handed to the frame being loaded; a drop in the
        // same cycle as a load is kept for the following frame.
        drop_pend_d = drop_pend_q;
        if (pop)  drop_pend_d = 1'b0;
        if (drop) drop_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            drop_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drop_pend_q <= drop_pend_d;
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = (state_q == SEND) ? frame_q[7:0] : 8'h00;
    assign overflow  = overflow_q;
    assign busy      = (count != '0) || (state_q == SEND);

endmodule

// File: tb/tb_math_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_math_result_serializer
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
// -----------------------------------------------------------------------------
module tb_math_result_serializer;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int NQ    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [15:0] in_q;
    logic       in_rmd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic [2:0] count;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int         mq[$];
    bit         mr[$];
    logic [7:0] mcur[$];
    bit         mpend;
    bit         movf;

    logic [7:0] log_q[$];

    math_result_serializer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_q      (in_q),
        .in_rmd    (in_rmd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] log_at(input int i);
        if (i < log_q.size()) return {8'h00, log_q[i]};
        return 16'hDEAD;
    endfunction

    // Model step at a rising edge with the inputs that edge sampled.
    task automatic model_edge(input bit rst, input bit v, input logic [15:0] q,
                              input bit r, input bit rdy);
        bit full;
        int qi;
        if (rst) begin
            mq.delete(); mr.delete(); mcur.delete();
            mpend = 0; movf = 0;
            return;
        end
        full = (mq.size() == DEPTH);
        if (mcur.size() > 0 && rdy) void'(mcur.pop_front());
        if (mcur.size() == 0 && mq.size() > 0) begin
            qi = mq.pop_front();
            for (int i = 0; i < NQ; i++) mcur.push_back(8'((qi >>> (8 * i)) & 255));
            mcur.push_back(8'(int'(mr.pop_front()) | (qi < 0 ? 2 : 0) | (mpend ? 4 : 0)));
            mpend = 0;
        end
        if (v) begin
            if (full) begin
                mpend = 1; movf = 1;
            end else begin
                mq.push_back(int'($signed(q)));
                mr.push_back(r);
            end
        end
    endtask

    // Called at a falling edge: drive, take the rising edge, return at next falling edge.
    task automatic cycle(input bit rst, input bit v, input logic [15:0] q,
                         input bit r, input bit rdy);
        if (chk_en && out_valid && rdy) log_q.push_back(out_data);
        reset = rst; in_valid = v; in_q = q; in_rmd = r; out_ready = rdy;
        @(posedge clk);
        model_edge(rst, v, q, r, rdy);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", {15'd0, out_valid}, {15'd0, mcur.size() > 0});
            chk("m_data", {8'd0, out_data}, {8'd0, (mcur.size() > 0) ? mcur[0] : 8'h00});
            chk("m_count", {13'd0, count}, 16'(mq.size()));
            chk("m_overflow", {15'd0, overflow}, {15'd0, movf});
            chk("m_busy", {15'd0, busy}, {15'd0, (mq.size() > 0) || (mcur.size() > 0)});
        end
    end

    initial begin
        int run, maxrun;
        reset = 1'b1; in_valid = 0; in_q = 0; in_rmd = 0; out_ready = 0;
        mpend = 0; movf = 0;
        @(negedge clk);
        cycle(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        cycle(1, 0, 0, 0, 0);
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_data", {8'd0, out_data}, 16'd0);
        chk("rst_count", {13'd0, count}, 16'd0);
        chk("rst_overflow", {15'd0, overflow}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);

        // Single result q=-3, rmd=1
        log_q.delete();
        cycle(0, 1, 16'hFFFD, 1, 1);
        chk("single_lat1_valid", {15'd0, out_valid}, 16'd0);
        cycle(0, 0, 0, 0, 1);
        chk("single_lat2_valid", {15'd0, out_valid}, 16'd1);
        chk("single_lat2_data", {8'd0, out_data}, 16'h00FD);
        repeat (4) cycle(0, 0, 0, 0, 1);
        chk("single_len", 16'(log_q.size()), 16'd3);
        chk("single_b0", log_at(0), 16'h00FD);
        chk("single_b1", log_at(1), 16'h00FF);
        chk("single_b2", log_at(2), 16'h0003);
        chk("single_busy", {15'd0, busy}, 16'd0);

        // Backpressure q=0x1234, rmd=0
        log_q.delete();
        cycle(0, 1, 16'h1234, 0, 0);
        repeat (5) begin
            cycle(0, 0, 0, 0, 0);
            chk("bp_hold_valid", {15'd0, out_valid}, 16'd1);
            chk("bp_hold_data", {8'd0, out_data}, 16'h0034);
        end
        repeat (5) cycle(0, 0, 0, 0, 1);
        chk("bp_b0", log_at(0), 16'h0034);
        chk("bp_b1", log_at(1), 16'h0012);
        chk("bp_b2", log_at(2), 16'h0000);

        // Burst overflow q=1..6 with the sink stalled
        log_q.delete();
        for (int k = 1; k <= 6; k++) cycle(0, 1, 16'(k), 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("burst_count", {13'd0, count}, 16'd4);
        chk("burst_overflow", {15'd0, overflow}, 16'd1);
        repeat (20) cycle(0, 0, 0, 0, 1);
        chk("burst_len", 16'(log_q.size()), 16'd15);
        chk("burst_q1_status", log_at(2), 16'h0000);
        chk("burst_q2_data", log_at(3), 16'h0002);
        chk("burst_q2_status", log_at(5), 16'h0004);
        chk("burst_q3_status", log_at(8), 16'h0000);
        chk("burst_q5_data", log_at(12), 16'h0005);

        // Back-to-back frames
        log_q.delete();
        cycle(0, 1, 16'h00AA, 0, 1);
        cycle(0, 1, 16'h8001, 1, 1);
        run = out_valid ? 1 : 0;
        maxrun = run;
        repeat (12) begin
            cycle(0, 0, 0, 0, 1);
            run = out_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
        end
        chk("b2b_run", 16'(maxrun), 16'd6);
        chk("b2b_b3", log_at(3), 16'h0001);
        chk("b2b_b4", log_at(4), 16'h0080);
        chk("b2b_b5", log_at(5), 16'h0003);

        // Push coinciding with a pop while full
        cycle(1, 0, 0, 0, 0);
        for (int k = 10; k <= 14; k++) cycle(0, 1, 16'(k), 0, 0);
        chk("pp_count_full", {13'd0, count}, 16'd4);
        chk("pp_overflow_pre", {15'd0, overflow}, 16'd0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 16'd99, 0, 1);
        chk("pp_count", {13'd0, count}, 16'd3);
        chk("pp_overflow", {15'd0, overflow}, 16'd1);
        chk("pp_next_data", {8'd0, out_data}, 16'd11);

        // Reset mid-frame after byte 0 is accepted
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        chk("rmid_valid", {15'd0, out_valid}, 16'd0);
        chk("rmid_count", {13'd0, count}, 16'd0);
        chk("rmid_overflow", {15'd0, overflow}, 16'd0);
        chk("rmid_busy", {15'd0, busy}, 16'd0);
        log_q.delete();
        cycle(0, 1, 16'hFED4, 0, 1);
        repeat (6) cycle(0, 0, 0, 0, 1);
        chk("rmid_len", 16'(log_q.size()), 16'd3);
        chk("rmid_b0", log_at(0), 16'h00D4);
        chk("rmid_b1", log_at(1), 16'h00FE);
        chk("rmid_b2", log_at(2), 16'h0002);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 99) < 45),
                  16'($urandom),
                  1'($urandom),
                  ($urandom_range(0, 99) < 65));
        end
        repeat (20) cycle(0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
